// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Two-master round-robin arbiter and sequencer for the single-port, clocked
//   data memory. Master 0 is the core load/store port, master 1 the
//   loader/debug port. One access is in flight at a time; all memory strobes
//   and handshake outputs are registered.
//
//   Build macro: DMEM_ARB_ALIGN_CHECK_EN
//     defined   -> a picked request that is misaligned or beyond the last
//                  word of memory is rejected (gnt + err pulse, no strobe).
//     undefined -> every request is forwarded unchanged, mN_err stays 0.
// ---------------------------------------------------------------------------

module dmem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_BYTES = 1024
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,

   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   // FSM encoding; the fourth code is unreachable and recovers to IDLE.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   // True when the byte address is word aligned and the whole word lies
   // inside the memory.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] limit;
      limit   = ADDR_W'(MEM_BYTES - 4);
      addr_ok = (addr[1:0] == 2'b00) && (addr <= limit);
   endfunction

   logic [1:0]        state_r;
   logic              last_gnt_r;   // master granted most recently
   logic              cur_mst_r;    // owner of the access in flight
   logic              need_resp_r;  // access in flight is an accepted read

   logic              pick_s;       // a request is chosen this cycle (IDLE only)
   logic              pick_mst_s;   // which master is chosen
   logic              sel_we_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;
   logic              reject_s;     // chosen request fails the range check
   logic              accept_s;     // chosen request goes to memory

   // Round-robin choice: a lone requester wins, a tie goes to the master
   // that was not granted last.
   always_comb begin
      pick_s     = 1'b0;
      pick_mst_s = 1'b0;
      if (state_r != ST_IDLE) begin
         pick_s     = 1'b0;
         pick_mst_s = last_gnt_r;
      end else if (m0_req && m1_req) begin
         pick_s     = 1'b1;
         pick_mst_s = ~last_gnt_r;
      end else if (m0_req) begin
         pick_s     = 1'b1;
         pick_mst_s = 1'b0;
      end else if (m1_req) begin
         pick_s     = 1'b1;
         pick_mst_s = 1'b1;
      end else begin
         pick_s     = 1'b0;
         pick_mst_s = last_gnt_r;
      end
   end

   // Request field mux for the chosen master.
   always_comb begin
      sel_we_s    = 1'b0;
      sel_addr_s  = {ADDR_W{1'b0}};
      sel_wdata_s = {DATA_W{1'b0}};
      if (pick_mst_s) begin
         sel_we_s    = m1_we;
         sel_addr_s  = m1_addr;
         sel_wdata_s = m1_wdata;
      end else begin
         sel_we_s    = m0_we;
         sel_addr_s  = m0_addr;
         sel_wdata_s = m0_wdata;
      end
   end

   // Optional range/alignment rejection of the chosen request.
   always_comb begin
      reject_s = 1'b0;
      accept_s = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      if (pick_s && !addr_ok(sel_addr_s)) begin
         reject_s = 1'b1;
      end else begin
         reject_s = 1'b0;
      end
`else
      reject_s = 1'b0;
`endif
      if (pick_s && !reject_s) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // FSM state, round-robin pointer and in-flight access bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         last_gnt_r  <= 1'b1;
         cur_mst_r   <= 1'b0;
         need_resp_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pick_s) begin
                  state_r     <= ST_ISSUE;
                  last_gnt_r  <= pick_mst_s;
                  cur_mst_r   <= pick_mst_s;
                  need_resp_r <= ~sel_we_s & ~reject_s;
               end
            end
            ST_ISSUE: begin
               if (need_resp_r) begin
                  state_r <= ST_RESP;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RESP: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Memory command bus: strobes last one cycle, address/data hold between accesses.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr  <= {ADDR_W{1'b0}};
         mem_wdata <= {DATA_W{1'b0}};
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end else if (accept_s) begin
         mem_addr  <= sel_addr_s;
         mem_wdata <= sel_wdata_s;
         mem_read  <= ~sel_we_s;
         mem_write <= sel_we_s;
      end else begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end
   end

   // Grant and reject pulses, aligned with the command on the memory bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         m0_gnt <= 1'b0;
         m1_gnt <= 1'b0;
         m0_err <= 1'b0;
         m1_err <= 1'b0;
      end else begin
         m0_gnt <= pick_s & ~pick_mst_s;
         m1_gnt <= pick_s &  pick_mst_s;
         m0_err <= reject_s & ~pick_mst_s;
         m1_err <= reject_s &  pick_mst_s;
      end
   end

   // Read response: capture memory data in RESP and pulse rvalid to its owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         m0_rdata  <= {DATA_W{1'b0}};
         m1_rdata  <= {DATA_W{1'b0}};
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
      end else if (state_r == ST_RESP) begin
         if (cur_mst_r) begin
            m1_rdata  <= mem_rdata;
            m1_rvalid <= 1'b1;
            m0_rvalid <= 1'b0;
         end else begin
            m0_rdata  <= mem_rdata;
            m0_rvalid <= 1'b1;
            m1_rvalid <= 1'b0;
         end
      end else begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter: directed scenarios followed by a
//   randomized two-master run compared against a cycle-count reference model.
//   Honours DMEM_ARB_ALIGN_CHECK_EN for the expected reject behaviour.
// ---------------------------------------------------------------------------

module tb_dmem_arbiter;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int MEM_BYTES = 1024;
   localparam int NCYC      = 800;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              m0_req, m0_we, m1_req, m1_we;
   logic [ADDR_W-1:0] m0_addr, m1_addr;
   logic [DATA_W-1:0] m0_wdata, m1_wdata;
   logic              m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [DATA_W-1:0] m0_rdata, m1_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              mem_read, mem_write;

   int checks = 0;
   int errors = 0;

   // environment memory, 256 words, with a backdoor write port for preloading
   logic [31:0] mem [0:255];
   logic        bd_we = 1'b0;
   logic [7:0]  bd_idx = 8'd0;
   logic [31:0] bd_data = 32'd0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   // clocked single-port memory: read data valid the cycle after mem_read
   always @(posedge clk) begin
      if (bd_we) mem[bd_idx] <= bd_data;
      else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
      if (mem_read) mem_rdata <= mem[mem_addr[9:2]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
   endtask

   task automatic bd_write(input logic [7:0] idx, input logic [31:0] data);
      bd_idx = idx; bd_data = data; bd_we = 1'b1;
      tick();
      bd_we = 1'b0;
   endtask

   task automatic test_reset();
      logic [135:0] vec;
      rst = 1'b1;
      idle_inputs();
      tick(); tick();
      vec = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_read, mem_write,
             mem_addr, mem_wdata, m0_rdata, m1_rdata};
      checks++;
      if (vec !== 136'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", vec); end
      rst = 1'b0;
      tick();
      vec = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_read, mem_write,
             mem_addr, mem_wdata, m0_rdata, m1_rdata};
      checks++;
      if (vec !== 136'd0) begin errors++; $display("FAIL idle_after_reset: got %h expected 0", vec); end
   endtask

   task automatic test_read();
      bd_write(8'h04, 32'hDEADBEEF);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
      tick();
      checks++;
      if ({m0_gnt, m1_gnt, mem_read, mem_write} !== 4'b1010) begin
         errors++; $display("FAIL read_gnt_strobe: got %b expected 1010", {m0_gnt, m1_gnt, mem_read, mem_write});
      end
      checks++;
      if (mem_addr !== 32'h10) begin errors++; $display("FAIL read_addr: got %h expected 10", mem_addr); end
      m0_req = 1'b0;
      tick();
      checks++;
      if ({m0_gnt, m0_rvalid, mem_read} !== 3'b000) begin
         errors++; $display("FAIL read_t2_quiet: got %b expected 000", {m0_gnt, m0_rvalid, mem_read});
      end
      tick();
      checks++;
      if ({m0_rvalid, m1_rvalid} !== 2'b10) begin
         errors++; $display("FAIL read_rvalid: got %b expected 10", {m0_rvalid, m1_rvalid});
      end
      checks++;
      if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata: got %h expected deadbeef", m0_rdata); end
      tick();
      checks++;
      if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL read_rdata_hold: got rvalid=%b rdata=%h expected 0/deadbeef", m0_rvalid, m0_rdata);
      end
   endtask

   task automatic test_write();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
      tick();
      checks++;
      if ({m0_gnt, m1_gnt, mem_read, mem_write} !== 4'b0101) begin
         errors++; $display("FAIL write_gnt_strobe: got %b expected 0101", {m0_gnt, m1_gnt, mem_read, mem_write});
      end
      checks++;
      if (mem_wdata !== 32'h12345678 || mem_addr !== 32'h20) begin
         errors++; $display("FAIL write_bus: got %h/%h expected 20/12345678", mem_addr, mem_wdata);
      end
      idle_inputs();
      tick();
      checks++;
      if (mem_write !== 1'b0 || mem_wdata !== 32'h12345678) begin
         errors++; $display("FAIL write_hold: got we=%b wdata=%h expected 0/12345678", mem_write, mem_wdata);
      end
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
      tick();
      checks++;
      if (m0_gnt !== 1'b1) begin errors++; $display("FAIL readback_gnt: got %b expected 1", m0_gnt); end
      idle_inputs();
      tick(); tick();
      checks++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h12345678) begin
         errors++; $display("FAIL readback_data: got rvalid=%b rdata=%h expected 1/12345678", m0_rvalid, m0_rdata);
      end
   endtask

   task automatic test_round_robin();
      logic e0, e1;
      rst = 1'b1;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'hA0A0A0A0;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h44; m1_wdata = 32'hB1B1B1B1;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         e0 = ((k % 4) == 1);
         e1 = ((k % 4) == 3);
         checks++;
         if ({m0_gnt, m1_gnt} !== {e0, e1}) begin
            errors++; $display("FAIL rr_grant k=%0d: got %b expected %b", k, {m0_gnt, m1_gnt}, {e0, e1});
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_issue();
      logic [135:0] vec;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
      tick();
      checks++;
      if (m0_gnt !== 1'b1 || mem_read !== 1'b1) begin
         errors++; $display("FAIL rst_issue_setup: got gnt=%b rd=%b expected 1/1", m0_gnt, mem_read);
      end
      idle_inputs();
      rst = 1'b1;
      tick();
      vec = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_read, mem_write,
             mem_addr, mem_wdata, m0_rdata, m1_rdata};
      checks++;
      if (vec !== 136'd0) begin errors++; $display("FAIL rst_issue_outputs: got %h expected 0", vec); end
      rst = 1'b0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
      tick();
      checks++;
      if ({m1_gnt, m0_rvalid, mem_read} !== 3'b101) begin
         errors++; $display("FAIL rst_issue_m1_gnt: got %b expected 101", {m1_gnt, m0_rvalid, mem_read});
      end
      idle_inputs();
      tick();
      checks++;
      if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL rst_issue_no_rvalid: got %b expected 0", m0_rvalid); end
      tick();
      checks++;
      if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'h12345678) begin
         errors++; $display("FAIL rst_issue_m1_read: got %b/%h expected 01/12345678", {m0_rvalid, m1_rvalid}, m1_rdata);
      end
   endtask

   task automatic test_align();
      logic [31:0] alist [3];
      logic [31:0] a;
      logic        bad, exp_err;
      alist[0] = 32'h13; alist[1] = 32'h3FE; alist[2] = 32'h3FC;
      for (int i = 0; i < 3; i++) begin
         a       = alist[i];
         bad     = (a[1:0] != 2'b00) || (a > 32'(MEM_BYTES - 4));
         exp_err = ALIGN_EN && bad;
         m0_req = 1'b1; m0_we = 1'b0; m0_addr = a;
         tick();
         checks++;
         if ({m0_gnt, m0_err, mem_read} !== {1'b1, exp_err, ~exp_err}) begin
            errors++; $display("FAIL align_%0h: got gnt/err/rd=%b expected %b", a,
                               {m0_gnt, m0_err, mem_read}, {1'b1, exp_err, ~exp_err});
         end
         idle_inputs();
         tick(); tick();
         checks++;
         if (m0_rvalid !== ~exp_err) begin
            errors++; $display("FAIL align_rvalid_%0h: got %b expected %b", a, m0_rvalid, ~exp_err);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d [3];
      for (int i = 0; i < 3; i++) d[i] = $urandom;
      m0_req = 1'b1; m0_we = 1'b1;
      for (int i = 0; i < 3; i++) begin
         m0_addr = 32'(4 * i); m0_wdata = d[i];
         tick();
         checks++;
         if (m0_gnt !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 32'(4 * i)) begin
            errors++; $display("FAIL b2b_gnt_%0d: got gnt=%b we=%b addr=%h expected 1/1/%h",
                               i, m0_gnt, mem_write, mem_addr, 32'(4 * i));
         end
         if (i == 2) idle_inputs();
         tick();
         checks++;
         if (m0_gnt !== 1'b0) begin errors++; $display("FAIL b2b_gap_%0d: got %b expected 0", i, m0_gnt); end
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (mem[i] !== d[i]) begin errors++; $display("FAIL b2b_mem_%0d: got %h expected %h", i, mem[i], d[i]); end
      end
   endtask

   task automatic test_random();
      logic [31:0] ref_mem [16];
      bit          exp_g [2][NCYC + 4];
      bit          exp_rv [2][NCYC + 4];
      logic [31:0] exp_rd [2][NCYC + 4];
      bit          pend [2];
      bit          pwe [2];
      logic [31:0] paddr [2];
      logic [31:0] pwdata [2];
      int          next_sample, w, idx;
      bit          last;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         bd_write(8'(64 + i), ref_mem[i]);
      end
      for (int c = 0; c < NCYC + 4; c++) begin
         for (int m = 0; m < 2; m++) begin exp_g[m][c] = 1'b0; exp_rv[m][c] = 1'b0; exp_rd[m][c] = 32'd0; end
      end
      for (int m = 0; m < 2; m++) begin pend[m] = 1'b0; pwe[m] = 1'b0; paddr[m] = 32'd0; pwdata[m] = 32'd0; end
      idle_inputs();
      rst = 1'b1; tick(); rst = 1'b0;
      next_sample = 0; last = 1'b1;
      for (int c = 0; c < NCYC; c++) begin
         checks++;
         if ({m0_gnt, m1_gnt} !== {exp_g[0][c], exp_g[1][c]}) begin
            errors++; $display("FAIL rand_gnt c=%0d: got %b expected %b", c, {m0_gnt, m1_gnt}, {exp_g[0][c], exp_g[1][c]});
         end
         checks++;
         if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== {exp_rv[0][c], exp_rv[1][c], 2'b00}) begin
            errors++; $display("FAIL rand_rvalid_err c=%0d: got %b expected %b", c,
                               {m0_rvalid, m1_rvalid, m0_err, m1_err}, {exp_rv[0][c], exp_rv[1][c], 2'b00});
         end
         if (exp_rv[0][c]) begin
            checks++;
            if (m0_rdata !== exp_rd[0][c]) begin errors++; $display("FAIL rand_m0_rdata c=%0d: got %h expected %h", c, m0_rdata, exp_rd[0][c]); end
         end
         if (exp_rv[1][c]) begin
            checks++;
            if (m1_rdata !== exp_rd[1][c]) begin errors++; $display("FAIL rand_m1_rdata c=%0d: got %h expected %h", c, m1_rdata, exp_rd[1][c]); end
         end
         // requesters: a granted request retires; idle masters may start a new one
         for (int m = 0; m < 2; m++) begin
            if (exp_g[m][c]) pend[m] = 1'b0;
            if (!pend[m] && ($urandom_range(0, 99) < 45)) begin
               pend[m]   = 1'b1;
               pwe[m]    = $urandom_range(0, 1) == 1;
               paddr[m]  = 32'h100 + 32'(4 * $urandom_range(0, 15));
               pwdata[m] = $urandom;
            end
         end
         m0_req = pend[0]; m0_we = pwe[0]; m0_addr = paddr[0]; m0_wdata = pwdata[0];
         m1_req = pend[1]; m1_we = pwe[1]; m1_addr = paddr[1]; m1_wdata = pwdata[1];
         // reference: arbiter free from next_sample; write busy 2 cycles, read 3
         if (c >= next_sample && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) w = last ? 0 : 1;
            else w = pend[1] ? 1 : 0;
            last = (w == 1);
            exp_g[w][c + 1] = 1'b1;
            idx = int'((paddr[w] - 32'h100) >> 2);
            if (pwe[w]) begin
               ref_mem[idx] = pwdata[w];
               next_sample  = c + 2;
            end else begin
               exp_rv[w][c + 3] = 1'b1;
               exp_rd[w][c + 3] = ref_mem[idx];
               next_sample      = c + 3;
            end
         end
         tick();
      end
      idle_inputs();
      tick(); tick(); tick();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_read();
      test_write();
      test_round_robin();
      test_reset_issue();
      test_align();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
